// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with grant hold and timeout
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nx;
    logic [1:0]        ptr, ptr_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [3:0]        gnt_nx;
    logic [1:0]        gnt_id_nx;
    logic              gnt_valid_nx, timeout_nx;
    logic [1:0]        scan_idx, sel;
    logic              found;
    logic              owner_req, hit_limit;

    // Scan ptr, ptr+1, ... with 2-bit wrap; the first requester found wins.
    always_comb begin
        sel      = ptr;
        found    = 1'b0;
        scan_idx = ptr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!found && req[scan_idx]) begin
                sel   = scan_idx;
                found = 1'b1;
            end
        end
    end

    assign owner_req = req[gnt_id];
    assign hit_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        hold_nx      = hold_cnt;
        gnt_nx       = gnt;
        gnt_id_nx    = gnt_id;
        gnt_valid_nx = gnt_valid;
        timeout_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx       = 4'b0001 << sel;
                    gnt_id_nx    = sel;
                    gnt_valid_nx = 1'b1;
                    hold_nx      = '0;
                    state_nx     = GRANT;
                end else begin
                    gnt_nx       = 4'b0000;
                    gnt_valid_nx = 1'b0;
                end
            end
            GRANT: begin
                if (done || !owner_req || hit_limit) begin
                    gnt_nx       = 4'b0000;
                    gnt_valid_nx = 1'b0;
                    ptr_nx       = gnt_id + 2'd1;
                    hold_nx      = '0;
                    state_nx     = IDLE;
                    // Timeout only flags a release forced purely by the hold limit.
                    timeout_nx   = hit_limit && !done && owner_req;
                end else if (hold_cnt != '1) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            gnt_valid <= gnt_valid_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule
